vga_timing_ctrl: RTL and testbench

Raster scheduler for the micro-VGA tile. Sequences the pixel datapath by generating horizontal/vertical sync, data-enable and the current pixel coordinates. Also emits line/frame strobes, which the pattern generator uses to fetch or update state. It sits between the tile clock and the `uo_out` colour/sync mapping. All downstream pixel logic keys off its outputs.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_axis_fsm.sv | 48 ++++
 rtl/vga_timing_ctrl.sv | 100 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: axis phase type, coordinate width and 640x480@60 default raster timing.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    typedef enum logic [1:0] {ACT, FP, SYNC, BP} axis_state_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned a, input int unsigned f,
                                               input int unsigned s, input int unsigned b);
        return a + f + s + b;
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: one raster axis -- position counter plus ACT/FP/SYNC/BP phase, advancing on step.
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned FRONT    = DEF_H_FP,
    parameter int unsigned SYNC_LEN = DEF_H_SYNC,
    parameter int unsigned BACK     = DEF_H_BP
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output axis_state_t        state,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] L_ACT_END  = COORD_W'(ACTIVE - 1);
    localparam logic [COORD_W-1:0] L_FP_END   = COORD_W'(ACTIVE + FRONT - 1);
    localparam logic [COORD_W-1:0] L_SYNC_END = COORD_W'(ACTIVE + FRONT + SYNC_LEN - 1);
    localparam logic [COORD_W-1:0] L_LAST     = COORD_W'(axis_total(ACTIVE, FRONT, SYNC_LEN, BACK) - 1);

    logic [COORD_W-1:0] r_count;
    axis_state_t        r_state;
    logic               w_last;

    assign w_last = (r_count == L_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_state <= ACT;
        end else if (step) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
            case (r_state)
                ACT:     if (r_count == L_ACT_END)  r_state <= FP;
                FP:      if (r_count == L_FP_END)   r_state <= SYNC;
                SYNC:    if (r_count == L_SYNC_END) r_state <= BP;
                default: if (w_last)                r_state <= ACT;
            endcase
        end
    end

    assign count = r_count;
    assign state = r_state;
    assign wrap  = step && w_last;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster timing generator (sync, data-enable, coordinates, line/frame strobes).
// Optional macro VGA_PIXDIV_EN halves the pixel tick rate with an internal phase flop.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    logic               w_tick;
    logic               w_first;
    logic [COORD_W-1:0] w_hcount, w_vcount;
    axis_state_t        w_hstate, w_vstate;
    logic               w_hwrap, w_vwrap;

`ifdef VGA_PIXDIV_EN
    logic r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phase <= 1'b0;
        else if (en) r_phase <= ~r_phase;
    end

    assign w_tick  = en && r_phase;
    assign w_first = en && !r_phase;
`else
    assign w_tick  = en;
    assign w_first = en;
`endif

    vga_axis_fsm #(.ACTIVE(H_ACTIVE), .FRONT(H_FP), .SYNC_LEN(H_SYNC), .BACK(H_BP)) u_h (
        .clk(clk), .rst(rst), .step(w_tick),
        .count(w_hcount), .state(w_hstate), .wrap(w_hwrap)
    );

    vga_axis_fsm #(.ACTIVE(V_ACTIVE), .FRONT(V_FP), .SYNC_LEN(V_SYNC), .BACK(V_BP)) u_v (
        .clk(clk), .rst(rst), .step(w_hwrap),
        .count(w_vcount), .state(w_vstate), .wrap(w_vwrap)
    );

    logic               r_h0, r_hv0;
    logic               r_hsync, r_vsync, r_de, r_ls, r_fs;
    logic [COORD_W-1:0] r_x, r_y;

    // r_h0 / r_hv0 flag that the held position is x=0 / (0,0); they follow the wraps on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h0    <= 1'b1;
            r_hv0   <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
            r_de    <= 1'b0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_ls <= w_first && r_h0;
            r_fs <= w_first && r_hv0;
            if (en) begin
                r_x     <= w_hcount;
                r_y     <= w_vcount;
                r_de    <= (w_hstate == ACT) && (w_vstate == ACT);
                r_hsync <= (w_hstate == SYNC) ? SYNC_POL : ~SYNC_POL;
                r_vsync <= (w_vstate == SYNC) ? SYNC_POL : ~SYNC_POL;
            end
            if (w_tick) begin
                r_h0  <= w_hwrap;
                r_hv0 <= w_vwrap;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance plus a tiny-raster instance for frame-level behaviour.
module tb_vga_timing_ctrl;

    localparam int unsigned S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int unsigned S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int unsigned S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int unsigned S_FR = S_HT * S_VT;
`ifdef VGA_PIXDIV_EN
    localparam int unsigned DIV = 2;
`else
    localparam int unsigned DIV = 1;
`endif
    localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    int unsigned pos  [2];
    int unsigned held [2];
    logic [24:0] exp_v[2];

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    function automatic logic [24:0] obs(input int k);
        if (k == 0) return {d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs};
        return {s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs};
    endfunction

    // Expected outputs for raster position p (linear pixel index since frame origin).
    function automatic logic [24:0] decode(input int k, input int unsigned p, input bit first);
        int unsigned ha, hf, hs, hb, va, vf, vs, vb, ht, vt, px, py;
        ha = (k == 0) ? 640 : S_HA;  hf = (k == 0) ? 16 : S_HF;
        hs = (k == 0) ? 96  : S_HS;  hb = (k == 0) ? 48 : S_HB;
        va = (k == 0) ? 480 : S_VA;  vf = (k == 0) ? 10 : S_VF;
        vs = (k == 0) ? 2   : S_VS;  vb = (k == 0) ? 33 : S_VB;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        px = p % ht;
        py = (p / ht) % vt;
        return {10'(px), 10'(py), 1'(px < ha && py < va),
                1'(!(px >= ha + hf && px < ha + hf + hs)),
                1'(!(py >= va + vf && py < va + vf + vs)),
                1'(first && px == 0), 1'(first && px == 0 && py == 0)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; held[k] = 0; exp_v[k] = RST_VEC;
        end
    endtask

    // One clock: drive en, advance the reference model at the edge, settle 1 time unit.
    task automatic cycle(input logic e);
        en = e;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            for (int k = 0; k < 2; k++) begin
                if (e) begin
                    exp_v[k] = decode(k, pos[k], held[k] == 0);
                    held[k]++;
                    if (held[k] == DIV) begin held[k] = 0; pos[k]++; end
                end else begin
                    exp_v[k][1:0] = 2'b00;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== RST_VEC) $display("FAIL reset_hold inst%0d got %h want %h", k, obs(k), RST_VEC);
                else n_pass++;
            end
        end
        rst = 1'b0;
        cycle(1'b1);
        n_total++;
        if ({d_de, d_ls, d_fs, d_x, d_y} !== {3'b111, 10'd0, 10'd0})
            $display("FAIL reset_release de/ls/fs/x/y got %b%b%b %0d %0d want 111 0 0", d_de, d_ls, d_fs, d_x, d_y);
        else n_pass++;
        n_total++;
        if ({s_de, s_ls, s_fs, s_x} !== {3'b111, 10'd0})
            $display("FAIL reset_release_small de/ls/fs/x got %b%b%b %0d want 111 0", s_de, s_ls, s_fs, s_x);
        else n_pass++;
    endtask

    task automatic test_line_timing();
        int unsigned lines = 0, last_ls = 0, de_cnt = 0, hs_cnt = 0, hs_x = 1023;
        bit hs_seen = 0;
        do_reset();
        for (int unsigned c = 1; c <= 3 * 800 * DIV; c++) begin
            cycle(1'b1);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL line_model inst%0d t=%0t got %h want %h", k, $time, obs(k), exp_v[k]);
                else n_pass++;
            end
            if (d_ls) begin
                if (lines > 0) begin
                    n_total++;
                    if (c - last_ls != 800 * DIV) $display("FAIL line_period got %0d want %0d", c - last_ls, 800 * DIV);
                    else n_pass++;
                end
                lines++;
                last_ls = c;
            end
            if (lines == 1) begin
                de_cnt += int'(d_de);
                if (!d_hs) begin
                    hs_cnt++;
                    if (!hs_seen) begin hs_seen = 1; hs_x = d_x; end
                end
            end
        end
        n_total++; if (lines != 3) $display("FAIL line_count got %0d want 3", lines); else n_pass++;
        n_total++; if (de_cnt != 640 * DIV) $display("FAIL de_high got %0d want %0d", de_cnt, 640 * DIV); else n_pass++;
        n_total++; if (800 * DIV - de_cnt != 160 * DIV) $display("FAIL de_low got %0d want %0d", 800 * DIV - de_cnt, 160 * DIV); else n_pass++;
        n_total++; if (hs_cnt != 96 * DIV) $display("FAIL hsync_width got %0d want %0d", hs_cnt, 96 * DIV); else n_pass++;
        n_total++; if (hs_x != 656) $display("FAIL hsync_start_x got %0d want 656", hs_x); else n_pass++;
    endtask

    task automatic test_frame_timing();
        int unsigned frames = 0, last_fs = 0, vs_cnt = 0, vs_x = 1023, vs_y = 1023, prev_y = 0;
        bit vs_seen = 0, wrapped = 0;
        do_reset();
        for (int unsigned c = 1; c <= 2 * S_FR * DIV + 1; c++) begin
            cycle(1'b1);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL frame_model inst%0d t=%0t got %h want %h", k, $time, obs(k), exp_v[k]);
                else n_pass++;
            end
            if (s_fs) begin
                if (frames > 0) begin
                    n_total++;
                    if (c - last_fs != S_FR * DIV) $display("FAIL frame_period got %0d want %0d", c - last_fs, S_FR * DIV);
                    else n_pass++;
                end
                frames++;
                last_fs = c;
            end
            if (frames == 1 && !s_vs) begin
                vs_cnt++;
                if (!vs_seen) begin vs_seen = 1; vs_x = s_x; vs_y = s_y; end
            end
            if (prev_y == S_VT - 1 && s_y == 10'd0) wrapped = 1;
            prev_y = s_y;
        end
        n_total++; if (frames != 3) $display("FAIL frame_count got %0d want 3", frames); else n_pass++;
        n_total++; if (vs_cnt != S_HT * S_VS * DIV) $display("FAIL vsync_width got %0d want %0d", vs_cnt, S_HT * S_VS * DIV); else n_pass++;
        n_total++; if (vs_x != 0 || vs_y != S_VA + S_VF) $display("FAIL vsync_start got (%0d,%0d) want (0,%0d)", vs_x, vs_y, S_VA + S_VF); else n_pass++;
        n_total++; if (wrapped !== 1'b1) $display("FAIL y_wrap got %b want 1", wrapped); else n_pass++;
    endtask

    task automatic test_enable_hold();
        bit found = 0;
        logic [9:0] prev_x = 10'd1023;
        for (int i = 0; i < 2000 * DIV && !found; i++) begin
            cycle(1'b1);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL hold_seek inst%0d got %h want %h", k, obs(k), exp_v[k]);
                else n_pass++;
            end
            if (d_x == 10'd100 && prev_x != 10'd100) found = 1;
            prev_x = d_x;
        end
        n_total++; if (!found) $display("FAIL hold_seek_timeout got x=%0d want 100", d_x); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL hold_model inst%0d got %h want %h", k, obs(k), exp_v[k]);
                else n_pass++;
            end
            n_total++;
            if (d_x !== 10'd100 || d_ls !== 1'b0 || d_fs !== 1'b0)
                $display("FAIL hold_x got x=%0d ls=%b fs=%b want x=100 ls=0 fs=0", d_x, d_ls, d_fs);
            else n_pass++;
        end
        cycle(1'b1);
        n_total++;
        if (d_x !== ((DIV == 1) ? 10'd101 : 10'd100)) $display("FAIL hold_resume got %0d want %0d", d_x, (DIV == 1) ? 101 : 100);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit found = 0;
        for (int i = 0; i < 2 * S_FR * DIV && !found; i++) begin
            cycle(1'b1);
            if (s_x == 10'd5 && s_y == 10'd10) found = 1;
        end
        n_total++; if (!found) $display("FAIL midrst_seek_timeout got (%0d,%0d) want (5,10)", s_x, s_y); else n_pass++;
        #3 rst = 1'b1;
        #1 model_reset();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs(k) !== RST_VEC) $display("FAIL midrst_async inst%0d got %h want %h", k, obs(k), RST_VEC);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL midrst_hold inst%0d got %h want %h", k, obs(k), exp_v[k]);
                else n_pass++;
            end
        end
        rst = 1'b0;
        cycle(1'b1);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs(k) !== exp_v[k]) $display("FAIL midrst_restart inst%0d got %h want %h", k, obs(k), exp_v[k]);
            else n_pass++;
        end
        n_total++;
        if ({s_fs, s_vs, s_x, s_y} !== {2'b11, 10'd0, 10'd0})
            $display("FAIL midrst_origin got fs=%b vs=%b (%0d,%0d) want fs=1 vs=1 (0,0)", s_fs, s_vs, s_x, s_y);
        else n_pass++;
    endtask

    task automatic test_random_en();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0));
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs(k) !== exp_v[k]) $display("FAIL random_en inst%0d t=%0t got %h want %h", k, $time, obs(k), exp_v[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_enable_hold();
        test_reset_mid_frame();
        test_random_en();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
